// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop
// produce diff = a - b (mod 2^WIDTH) and borrow = (a < b), LSB first, one bit
// per clock, behind a start/busy/done handshake.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bw_q, bw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // Full-subtractor cell working on the current LSBs of the operand registers.
  logic             bit_diff;
  logic             bit_borrow;
  logic [WIDTH-1:0] res_shift;

  assign bit_diff   = a_q[0] ^ b_q[0] ^ bw_q;
  assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  // New bit enters from the MSB side so that after WIDTH shifts the LSB lands at bit 0.
  assign res_shift  = {bit_diff, res_q[WIDTH-1:1]};

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          res_d   = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bw_d  = bit_borrow;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish the completed word and final borrow; they hold until the next completion.
          diff_d   = res_shift;
          borrow_d = bit_borrow;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run and clears everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy_out   = (state_q == RUN);
  assign done_out   = (state_q == DONE);
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;

endmodule
